// File: rtl/sample_fetch_pwm_pkg.sv
// Shared definitions for the sample fetch / PWM playback path.
// The sample rate is also used by the playback address generator.
package sample_fetch_pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

    localparam logic [7:0] PCM_SILENCE = 8'h80;
    localparam int SAMPLE_RATE = 3000;

endpackage

// File: rtl/sample_fetch_pwm_pwm_dac.sv
// 1-bit PWM DAC: free-running period counter, active duty register
// reloaded only at the period boundary, registered compare output.
module sample_fetch_pwm_pwm_dac
    import sample_fetch_pwm_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] SILENCE = DATA_W'(PCM_SILENCE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              load_pending,
    output logic              period_end,
    output logic              pwm_out
);

    logic [DATA_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DATA_W-1:0] active_q, active_d;
    logic              pwm_out_q, pwm_out_d;

    assign period_end = &pwm_cnt_q;
    assign pwm_out    = pwm_out_q;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + DATA_W'(1);
        pwm_out_d = pwm_cnt_q < active_q;
        active_d  = active_q;
        // New duty takes effect from the count that follows the wrap
        if (period_end && load_pending) begin
            active_d = sample_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt_q <= '0;
            active_q  <= SILENCE;
            pwm_out_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            active_q  <= active_d;
            pwm_out_q <= pwm_out_d;
        end
    end

endmodule

// File: rtl/sample_fetch_pwm.sv
// Fetches one PCM sample per tick over a req/valid port, double-buffers
// it and plays it through the PWM DAC; sticky overrun/underrun flags.
module sample_fetch_pwm
    import sample_fetch_pwm_pkg::*;
#(
    parameter int                ADDR_W  = 22,
    parameter int                DATA_W  = 8,
    parameter int                TIMEOUT = 16,
    parameter logic [DATA_W-1:0] SILENCE = DATA_W'(PCM_SILENCE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              count,
    input  logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              clear_flags,
    output logic              pwm_out,
    output logic              overrun,
    output logic              underrun
);

    localparam int TW = $clog2(TIMEOUT + 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] pending_q, pending_d;
    logic              pend_full_q, pend_full_d;
    logic              overrun_q, overrun_d;
    logic              underrun_q, underrun_d;
    logic              ov_set, un_set;
    logic              period_end;

    assign mem_addr = mem_addr_q;
    assign mem_req  = mem_req_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        timer_d     = timer_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        ov_set      = 1'b0;
        un_set      = 1'b0;

        // The DAC takes the buffered sample at the wrap
        if (period_end && pend_full_q) begin
            pend_full_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (count) begin
                    state_d    = REQ;
                    mem_addr_d = endereco;
                    mem_req_d  = 1'b1;
                    timer_d    = '0;
                end
            end
            REQ: begin
                if (count) begin
                    ov_set = 1'b1;
                end
                if (mem_rvalid) begin
                    pending_d   = mem_rdata;
                    pend_full_d = 1'b1;
                    mem_req_d   = 1'b0;
                    state_d     = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    un_set    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        overrun_d  = (overrun_q & ~clear_flags) | ov_set;
        underrun_d = (underrun_q & ~clear_flags) | un_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            timer_q     <= '0;
            pending_q   <= SILENCE;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    sample_fetch_pwm_pwm_dac #(
        .DATA_W  (DATA_W),
        .SILENCE (SILENCE)
    ) u_dac (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (pending_q),
        .load_pending (pend_full_q),
        .period_end   (period_end),
        .pwm_out      (pwm_out)
    );

endmodule

// File: tb/tb_sample_fetch_pwm.sv
// Directed plus randomized bench for sample_fetch_pwm against a
// transaction-level reference model.
module tb_sample_fetch_pwm;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        count = 1'b0;
    logic [21:0] endereco = '0;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        clear_flags = 1'b0;
    logic [21:0] mem_addr;
    logic        mem_req;
    logic        pwm_out;
    logic        overrun;
    logic        underrun;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sample_fetch_pwm dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .endereco    (endereco),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .clear_flags (clear_flags),
        .pwm_out     (pwm_out),
        .overrun     (overrun),
        .underrun    (underrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one outstanding fetch with an issue timestamp,
    // PWM phase derived from the cycle count since reset.
    typedef struct {
        int unsigned cyc;
        int unsigned start;
        bit          busy;
        bit          full;
        bit          out;
        bit          ov;
        bit          un;
        logic [21:0] addr;
        logic [7:0]  pend;
        logic [7:0]  act;
    } model_t;

    function automatic model_t m_reset();
        model_t s;
        s.cyc = 0; s.start = 0; s.busy = 0; s.full = 0;
        s.out = 0; s.ov = 0; s.un = 0; s.addr = '0;
        s.pend = 8'h80; s.act = 8'h80;
        return s;
    endfunction

    function automatic model_t m_step(model_t s, bit cnt, bit rv,
                                      logic [7:0] rd, logic [21:0] ea,
                                      bit clr);
        model_t n = s;
        logic [7:0] phase = 8'(s.cyc);
        bit ovs = 0;
        bit uns = 0;
        n.out = phase < s.act;
        if (phase == 8'd255 && s.full) begin
            n.act  = s.pend;
            n.full = 0;
        end
        if (s.busy) begin
            ovs = cnt;
            if (rv) begin
                n.pend = rd;
                n.full = 1;
                n.busy = 0;
            end else if ((s.cyc - s.start) == 32'(TIMEOUT)) begin
                n.busy = 0;
                uns = 1;
            end
        end else if (cnt) begin
            n.busy  = 1;
            n.addr  = ea;
            n.start = s.cyc;
        end
        n.ov = (s.ov && !clr) || ovs;
        n.un = (s.un && !clr) || uns;
        n.cyc = s.cyc + 1;
        return n;
    endfunction

    model_t m = m_reset();

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= m_reset();
        else m <= m_step(m, count, mem_rvalid, mem_rdata,
                         endereco, clear_flags);
    end

    always @(negedge clk) begin
        chk("mem_req", 32'(mem_req), 32'(m.busy));
        chk("mem_addr", 32'(mem_addr), 32'(m.addr));
        chk("pwm_out", 32'(pwm_out), 32'(m.out));
        chk("overrun", 32'(overrun), 32'(m.ov));
        chk("underrun", 32'(underrun), 32'(m.un));
    end

    task automatic quiet();
        count = 0;
        mem_rvalid = 0;
        clear_flags = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            quiet();
        end
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(negedge clk);
            quiet();
            if (pwm_out) h++;
        end
    endtask

    task automatic wait_phase(input logic [7:0] p);
        for (int k = 0; k < 300; k++) begin
            if (8'(m.cyc) == p) break;
            @(negedge clk);
            quiet();
        end
    endtask

    initial begin
        int h;
        int reqc;
        int rises;
        bit prev;
        int age;
        int lat;

        #1 reset = 0;
        repeat (10) begin
            @(negedge clk);
            count = 1'($urandom);
            endereco = 22'($urandom);
            mem_rvalid = 1'($urandom);
            mem_rdata = 8'($urandom);
            clear_flags = 1'($urandom);
            #1;
            chk("rst_req", 32'(mem_req), 0);
            chk("rst_pwm", 32'(pwm_out), 0);
            chk("rst_ovr", 32'(overrun), 0);
            chk("rst_unr", 32'(underrun), 0);
        end
        @(negedge clk);
        quiet();
        reset = 1;
        count_high(256, h);
        chk("silence_duty", 32'(h), 128);

        @(negedge clk);
        count = 1;
        endereco = 22'd1234;
        reqc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            quiet();
            endereco = 22'($urandom);
            mem_rvalid = (i == 2);
            mem_rdata = 8'h40;
            if (mem_req) reqc++;
            if (i == 0) chk("fetch_addr", 32'(mem_addr), 1234);
        end
        chk("fetch_req_len", 32'(reqc), 3);
        idle(300);
        count_high(256, h);
        chk("duty_40", 32'(h), 64);

        @(negedge clk);
        count = 1;
        reqc = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            quiet();
            if (mem_req) reqc++;
        end
        chk("timeout_len", 32'(reqc), 16);
        chk("underrun_set", 32'(underrun), 1);
        count_high(256, h);
        chk("duty_hold", 32'(h), 64);
        @(negedge clk);
        clear_flags = 1;
        @(negedge clk);
        quiet();
        chk("underrun_clr", 32'(underrun), 0);

        @(negedge clk);
        count = 1;
        rises = 0;
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            quiet();
            count = (i == 2);
            mem_rvalid = (i == 3);
            mem_rdata = 8'hFF;
            if (mem_req && !prev) rises++;
            prev = mem_req;
        end
        chk("overrun_fetches", 32'(rises), 1);
        chk("overrun_set", 32'(overrun), 1);
        idle(300);
        count_high(256, h);
        chk("duty_ff", 32'(h), 255);

        wait_phase(8'd5);
        count = 1;
        @(negedge clk);
        quiet();
        @(negedge clk);
        mem_rvalid = 1;
        mem_rdata = 8'h20;
        @(negedge clk);
        quiet();
        wait_phase(8'd250);
        count = 1;
        @(negedge clk);
        quiet();
        wait_phase(8'd255);
        chk("bnd_req_open", 32'(mem_req), 1);
        mem_rvalid = 1;
        mem_rdata = 8'h10;
        @(negedge clk);
        quiet();
        count_high(256, h);
        chk("bnd_duty_20", 32'(h), 32'h20);
        count_high(256, h);
        chk("bnd_duty_10", 32'(h), 32'h10);

        @(negedge clk);
        count = 1;
        @(negedge clk);
        quiet();
        @(posedge clk);
        #2 reset = 0;
        #1 chk("async_req_drop", 32'(mem_req), 0);
        @(negedge clk);
        reset = 1;
        reqc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            quiet();
            mem_rvalid = 1'($urandom);
            if (mem_req) reqc++;
        end
        chk("no_resume", 32'(reqc), 0);
        @(negedge clk);
        quiet();
        count = 1;
        @(negedge clk);
        quiet();
        chk("refetch_req", 32'(mem_req), 1);
        mem_rvalid = 1;
        mem_rdata = 8'($urandom);
        @(negedge clk);
        quiet();

        age = -1;
        lat = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            count = ($urandom_range(0, 39) == 0);
            endereco = 22'($urandom);
            clear_flags = ($urandom_range(0, 63) == 0);
            mem_rdata = 8'($urandom);
            if (mem_req) begin
                if (age < 0) begin
                    age = 0;
                    lat = int'($urandom_range(0, 19));
                end else begin
                    age++;
                end
                mem_rvalid = (age == lat);
            end else begin
                age = -1;
                mem_rvalid = ($urandom_range(0, 15) == 0);
            end
        end
        idle(4);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
